sfp_link_supervisor: RTL and testbench

SFP_LINK_SUPERVISOR -- requirements
Module: sfp_link_supervisor

---
 rtl/sfp_link_supervisor.sv | 167 ++++++++++++++++
 tb/tb_sfp_link_supervisor.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sfp_link_supervisor.sv
// SFP link supervisor: watches per-lane link-up, pulses a system reset request
// when the links stay down too long, and gives up after a bounded number of retries.
//
// state          | meaning
// WAIT_LINK      | links not all up; timeout timer running
// LINK_OK        | all lanes up; retry count cleared
// RESET_PULSE    | driving user_reset_out for RST_PULSE_CYCLES cycles
// FAIL           | retries exhausted; held until sys_reset
module sfp_link_supervisor #(
  parameter int SFP_COUNT        = 2,
  parameter int TIMEOUT_CYCLES   = 100000000,
  parameter int RST_PULSE_CYCLES = 1000,
  parameter int MAX_RETRY        = 3,
  parameter int BLINK_DIV        = 25000000
) (
  input  logic                 sysclk_100m,
  input  logic                 sys_reset,
  input  logic [SFP_COUNT-1:0] link_status,
  output logic                 user_reset_out,
  output logic [3:0]           sleds,
  output logic [7:0]           retry_count
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam int PC_W  = $clog2(RST_PULSE_CYCLES + 1);
  localparam int HB_W  = $clog2(BLINK_DIV + 1);

  localparam logic [TMR_W-1:0] TMR_LAST    = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PC_W-1:0]  PULSE_LAST  = PC_W'(RST_PULSE_CYCLES);
  localparam logic [HB_W-1:0]  HB_LAST     = HB_W'(BLINK_DIV - 1);
  localparam logic [7:0]       MAX_RETRY_L = 8'(MAX_RETRY);

  typedef enum logic [1:0] {
    WAIT_LINK   = 2'd0,
    LINK_OK     = 2'd1,
    RESET_PULSE = 2'd2,
    FAIL        = 2'd3
  } state_t;

  state_t               state;
  logic [TMR_W-1:0]     timer;
  logic [PC_W-1:0]      pulse_cnt;
  logic [HB_W-1:0]      hb_cnt;
  logic                 hb;
  logic                 hb_wrap;
  logic                 hb_next;
  logic [SFP_COUNT-1:0] sync1;
  logic [SFP_COUNT-1:0] sync2;
  logic                 all_up;
  logic                 lane1_sync;
  logic                 led_lane0;
  logic                 led_lane1;
  logic                 led_state;

  // link_status is asynchronous; two flops per lane before anything looks at it
  always_ff @(posedge sysclk_100m) begin
    if (sys_reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= link_status;
      sync2 <= sync1;
    end
  end

  assign all_up = &sync2;

  if (SFP_COUNT > 1) begin : g_lane1
    assign lane1_sync = sync2[SFP_COUNT-1];
  end else begin : g_no_lane1
    assign lane1_sync = 1'b0;
  end

  assign hb_wrap = (hb_cnt == HB_LAST);
  assign hb_next = hb_wrap ? ~hb : hb;

  always_ff @(posedge sysclk_100m) begin
    if (sys_reset) begin
      hb_cnt    <= '0;
      hb        <= 1'b0;
      led_lane0 <= 1'b0;
      led_lane1 <= 1'b0;
    end else begin
      hb_cnt    <= hb_wrap ? '0 : hb_cnt + 1'b1;
      hb        <= hb_next;
      led_lane0 <= sync2[0];
      led_lane1 <= lane1_sync;
    end
  end

  // led_state is loaded with the value matching the state being entered, so it
  // lines up with the registered state and the heartbeat on the same edge
  always_ff @(posedge sysclk_100m) begin
    if (sys_reset) begin
      state          <= WAIT_LINK;
      timer          <= '0;
      pulse_cnt      <= '0;
      retry_count    <= 8'd0;
      user_reset_out <= 1'b0;
      led_state      <= 1'b0;
    end else begin
      case (state)
        WAIT_LINK: begin
          if (all_up) begin
            state       <= LINK_OK;
            timer       <= '0;
            retry_count <= 8'd0;
            led_state   <= 1'b0;
          end else if (timer == TMR_LAST) begin
            timer <= '0;
            if (retry_count < MAX_RETRY_L) begin
              state       <= RESET_PULSE;
              pulse_cnt   <= '0;
              retry_count <= (retry_count == 8'hFF) ? retry_count : retry_count + 8'd1;
              led_state   <= hb_next;
            end else begin
              state     <= FAIL;
              led_state <= 1'b1;
            end
          end else begin
            timer     <= timer + 1'b1;
            led_state <= hb_next;
          end
        end

        LINK_OK: begin
          if (!all_up) begin
            state     <= WAIT_LINK;
            timer     <= '0;
            led_state <= hb_next;
          end else begin
            led_state <= 1'b0;
          end
        end

        RESET_PULSE: begin
          led_state <= hb_next;
          if (pulse_cnt == PULSE_LAST) begin
            state          <= WAIT_LINK;
            timer          <= '0;
            pulse_cnt      <= '0;
            user_reset_out <= 1'b0;
          end else begin
            pulse_cnt      <= pulse_cnt + 1'b1;
            user_reset_out <= 1'b1;
          end
        end

        FAIL: begin
          user_reset_out <= 1'b0;
          led_state      <= 1'b1;
        end

        default: begin
          state          <= WAIT_LINK;
          timer          <= '0;
          pulse_cnt      <= '0;
          user_reset_out <= 1'b0;
          led_state      <= 1'b0;
        end
      endcase
    end
  end

  assign sleds = {led_state, led_lane1, led_lane0, hb};

endmodule

// File: tb/tb_sfp_link_supervisor.sv
// Bench for sfp_link_supervisor: directed scenarios plus random link activity
// compared against a timestamp-based behavioural model.
module tb_sfp_link_supervisor;
  localparam int SFP  = 2;
  localparam int TMO  = 16;
  localparam int PW   = 4;
  localparam int MAXR = 2;
  localparam int BD   = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] link;
  logic       uro;
  logic [3:0] sleds;
  logic [7:0] retry;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sfp_link_supervisor #(
    .SFP_COUNT(SFP), .TIMEOUT_CYCLES(TMO), .RST_PULSE_CYCLES(PW),
    .MAX_RETRY(MAXR), .BLINK_DIV(BD)
  ) dut (
    .sysclk_100m(clk), .sys_reset(rst), .link_status(link),
    .user_reset_out(uro), .sleds(sleds), .retry_count(retry)
  );

  // Model: modes 0=waiting 1=up 2=pulsing 3=failed; m_entry is the edge number
  // at which the current mode began, m_cyc counts edges since reset.
  int         m_mode, m_cyc, m_entry;
  logic [7:0] m_retry;
  logic       m_uro;
  logic [1:0] m_h1, m_h2;
  logic [3:0] m_leds;

  task automatic model_edge(input logic r, input logic [1:0] ls);
    logic [1:0] seen;
    logic       up, hbv, l3;
    int         age;
    if (r) begin
      m_mode = 0; m_cyc = 0; m_entry = 0; m_retry = 8'd0; m_uro = 1'b0;
      m_h1 = 2'b00; m_h2 = 2'b00; m_leds = 4'b0000;
      return;
    end
    seen = m_h2;
    up   = &seen;
    m_h2 = m_h1;
    m_h1 = ls;
    m_cyc++;
    age = m_cyc - m_entry;
    case (m_mode)
      0: if (up) begin
           m_mode = 1; m_retry = 8'd0; m_entry = m_cyc;
         end else if (age == TMO) begin
           m_entry = m_cyc;
           if (int'(m_retry) < MAXR) begin
             m_mode = 2;
             if (m_retry != 8'hFF) m_retry = m_retry + 8'd1;
           end else m_mode = 3;
         end
      1: if (!up) begin m_mode = 0; m_entry = m_cyc; end
      2: if (age == PW + 1) begin m_mode = 0; m_entry = m_cyc; end
      default: ;
    endcase
    m_uro = (m_mode == 2) && (m_cyc - m_entry >= 1) && (m_cyc - m_entry <= PW);
    hbv   = ((m_cyc / BD) % 2) == 1;
    l3    = (m_mode == 1) ? 1'b0 : (m_mode == 3) ? 1'b1 : hbv;
    m_leds = {l3, seen[1], seen[0], hbv};
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(rst, link);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] ls);
    rst = 1'b1; link = ls;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(2'b11);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if (uro !== 1'b0) begin n_fail++; $display("FAIL reset_uro: got %b expected 0", uro); end
    n_checks++;
    if (sleds !== 4'b0000) begin n_fail++; $display("FAIL reset_sleds: got %b expected 0000", sleds); end
    n_checks++;
    if (retry !== 8'd0) begin n_fail++; $display("FAIL reset_retry: got %0d expected 0", retry); end
    rst = 1'b0;
  endtask

  task automatic test_link_up();
    do_reset(2'b11);
    for (int n = 1; n <= 12; n++) begin
      tick();
      n_checks++;
      if (uro !== 1'b0) begin n_fail++; $display("FAIL linkup_uro n=%0d: got %b expected 0", n, uro); end
      if (n < 3) begin
        n_checks++;
        if (sleds[3:1] !== 3'b000) begin n_fail++; $display("FAIL linkup_early n=%0d: got %b expected 000", n, sleds[3:1]); end
      end else begin
        n_checks++;
        if (sleds[3:1] !== 3'b011) begin n_fail++; $display("FAIL linkup_leds n=%0d: got %b expected 011", n, sleds[3:1]); end
      end
    end
    n_checks++;
    if (retry !== 8'd0) begin n_fail++; $display("FAIL linkup_retry: got %0d expected 0", retry); end
  endtask

  task automatic test_retry_to_fail();
    int high = 0, rise1 = -1, rise2 = -1;
    logic prev = 1'b0;
    do_reset(2'b01);
    for (int n = 1; n <= 70; n++) begin
      tick();
      if (uro && !prev) begin
        if (rise1 < 0) rise1 = n; else if (rise2 < 0) rise2 = n;
      end
      prev = uro;
      if (uro) high++;
      if (n == 15 || n == 16 || n == 37) begin
        n_checks++;
        if (retry !== ((n == 15) ? 8'd0 : (n == 16) ? 8'd1 : 8'd2)) begin
          n_fail++; $display("FAIL fail_retry n=%0d: got %0d", n, retry);
        end
      end
    end
    n_checks++;
    if (high != 2 * PW) begin n_fail++; $display("FAIL fail_pulse_len: got %0d expected %0d", high, 2 * PW); end
    n_checks++;
    if (rise1 != 17 || rise2 != 38) begin n_fail++; $display("FAIL fail_pulse_start: got %0d,%0d expected 17,38", rise1, rise2); end
    n_checks++;
    if (sleds !== 4'b1010) begin n_fail++; $display("FAIL fail_leds: got %b expected 1010", sleds); end
    n_checks++;
    if (retry !== 8'd2) begin n_fail++; $display("FAIL fail_retry_final: got %0d expected 2", retry); end
  endtask

  task automatic test_timeout_boundary();
    do_reset(2'b00);
    for (int n = 1; n <= 30; n++) begin
      link = (n >= 14) ? 2'b11 : 2'b00;
      tick();
      n_checks++;
      if (uro !== 1'b0) begin n_fail++; $display("FAIL bound_uro n=%0d: got %b expected 0", n, uro); end
      if (n == 15 || n == 16 || n == 24) begin
        n_checks++;
        if (sleds !== ((n == 15) ? 4'b1001 : (n == 16) ? 4'b0110 : 4'b0111)) begin
          n_fail++; $display("FAIL bound_leds n=%0d: got %b", n, sleds);
        end
      end
    end
    n_checks++;
    if (retry !== 8'd0) begin n_fail++; $display("FAIL bound_retry: got %0d expected 0", retry); end
  endtask

  task automatic test_retry_then_up();
    int high = 0;
    do_reset(2'b00);
    for (int n = 1; n <= 45; n++) begin
      link = (n < 23) ? 2'b00 : (n < 30) ? 2'b11 : 2'b01;
      tick();
      if (uro) high++;
      if (n == 24 || n == 25 || n == 45) begin
        n_checks++;
        if (retry !== ((n == 24) ? 8'd1 : 8'd0)) begin n_fail++; $display("FAIL up_retry n=%0d: got %0d", n, retry); end
      end
      if (n == 31 || n == 33 || n == 40) begin
        n_checks++;
        if (sleds !== ((n == 31) ? 4'b0111 : (n == 33) ? 4'b0010 : 4'b1011)) begin
          n_fail++; $display("FAIL up_leds n=%0d: got %b", n, sleds);
        end
      end
    end
    n_checks++;
    if (high != PW) begin n_fail++; $display("FAIL up_pulse_len: got %0d expected %0d", high, PW); end
  endtask

  task automatic test_reset_mid_pulse();
    do_reset(2'b00);
    repeat (18) tick();
    n_checks++;
    if (uro !== 1'b1) begin n_fail++; $display("FAIL mid_pulse_active: got %b expected 1", uro); end
    rst = 1'b1;
    tick();
    n_checks++;
    if ({uro, sleds, retry} !== 13'd0) begin n_fail++; $display("FAIL mid_pulse_reset: got %b expected all 0", {uro, sleds, retry}); end
    rst = 1'b0;
    for (int n = 1; n <= 17; n++) begin
      tick();
      n_checks++;
      if (uro !== (n == 17)) begin n_fail++; $display("FAIL mid_pulse_restart n=%0d: got %b", n, uro); end
    end
  endtask

  task automatic test_heartbeat();
    logic prev;
    do_reset(2'b00);
    prev = 1'b0;
    for (int n = 1; n <= 96; n++) begin
      tick();
      n_checks++;
      if ((sleds[0] !== prev) !== (n % BD == 0)) begin
        n_fail++; $display("FAIL heartbeat n=%0d: led0 %b prev %b", n, sleds[0], prev);
      end
      prev = sleds[0];
    end
    n_checks++;
    if (sleds[3] !== 1'b1) begin n_fail++; $display("FAIL heartbeat_fail_led: got %b expected 1", sleds[3]); end
  endtask

  task automatic test_random();
    do_reset(2'($urandom));
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 15) == 0) link = 2'($urandom);
      rst = ($urandom_range(0, 599) == 0);
      tick();
      n_checks++;
      if ({uro, sleds, retry} !== {m_uro, m_leds, m_retry}) begin
        n_fail++;
        $display("FAIL random n=%0d: got uro=%b leds=%b retry=%0d expected uro=%b leds=%b retry=%0d",
                 n, uro, sleds, retry, m_uro, m_leds, m_retry);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    link = 2'b00;
    test_reset();
    test_link_up();
    test_retry_to_fail();
    test_timeout_boundary();
    test_retry_then_up();
    test_reset_mid_pulse();
    test_heartbeat();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
